// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: default widths, opcode constants, ALU classes
// and the control bundle carried through the ID/EX register.
package legv8_pkg;

   localparam int unsigned WORD_DEF      = 64;
   localparam int unsigned INSTR_LEN_DEF = 32;
   localparam int unsigned REG_IDX_W     = 5;
   localparam int unsigned OPCODE_W      = 11;
   localparam int unsigned NUM_REGS      = 32;

   localparam logic [REG_IDX_W-1:0] ZERO_REG_DEF = 5'd31;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [OPCODE_W-1:0] OP_AND  = 11'b100_0101_0000;
   localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b101_0101_0000;
   localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [OPCODE_W-1:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [7:0]          OP_CBZ  = 8'b1011_0100;
   localparam logic [5:0]          OP_B    = 6'b00_0101;

   typedef enum logic [1:0] {
      ALU_LDST  = 2'b00,
      ALU_CBZ   = 2'b01,
      ALU_RTYPE = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic    uncond_branch;
      logic    branch;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      alu_op_e alu_op;
   } ctrl_t;

   function automatic logic is_rtype(input logic [OPCODE_W-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
   endfunction

endpackage

// File: rtl/legv8_regfile.sv
// 32-entry LEGv8 register file: two combinational reads, one synchronous write,
// hard-wired zero register. LEGV8_ID_BYPASS_EN forwards a same-cycle write to the reads.
module legv8_regfile
   import legv8_pkg::*;
#(
   parameter int unsigned           WORD     = WORD_DEF,
   parameter logic [REG_IDX_W-1:0]  ZERO_REG = ZERO_REG_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] rd_idx1,
   input  logic [REG_IDX_W-1:0] rd_idx2,
   output logic [WORD-1:0]      rd_data1_c,
   output logic [WORD-1:0]      rd_data2_c,
   input  logic                 wr_en,
   input  logic [REG_IDX_W-1:0] wr_idx,
   input  logic [WORD-1:0]      wr_data
);

   logic [WORD-1:0] regs [NUM_REGS];
   logic            wr_live;

   assign wr_live = wr_en && (wr_idx != ZERO_REG);

   // Storage; the zero register is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[REG_IDX_W'(i)] <= '0;
         end
      end else if (wr_live) begin
         regs[wr_idx] <= wr_data;
      end
   end

   // Read ports.
   always_comb begin
      rd_data1_c = (rd_idx1 == ZERO_REG) ? '0 : regs[rd_idx1];
      rd_data2_c = (rd_idx2 == ZERO_REG) ? '0 : regs[rd_idx2];
`ifdef LEGV8_ID_BYPASS_EN
      if (wr_live && (wr_idx == rd_idx1)) rd_data1_c = wr_data;
      if (wr_live && (wr_idx == rd_idx2)) rd_data2_c = wr_data;
`endif
   end

endmodule

// File: rtl/legv8_id_stage.sv
// LEGv8 instruction-decode stage with registered ID/EX, load-use stall, flush and
// illegal-opcode flag. LEGV8_ID_BYPASS_EN selects writeback forwarding over stalling.
module legv8_id_stage
   import legv8_pkg::*;
#(
   parameter int unsigned           WORD      = WORD_DEF,
   parameter int unsigned           INSTR_LEN = INSTR_LEN_DEF,
   parameter logic [REG_IDX_W-1:0]  ZERO_REG  = ZERO_REG_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_LEN-1:0] in_instr,
   input  logic [WORD-1:0]      in_pc,
   input  logic                 flush,
   input  logic                 wb_en,
   input  logic [4:0]           wb_reg,
   input  logic [WORD-1:0]      wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD-1:0]      out_pc,
   output logic [WORD-1:0]      out_read_data1,
   output logic [WORD-1:0]      out_read_data2,
   output logic [WORD-1:0]      out_sign_ext,
   output logic [10:0]          out_opcode,
   output logic [4:0]           out_rd,
   output logic                 out_uncond_branch,
   output logic                 out_branch,
   output logic                 out_mem_read,
   output logic                 out_mem_to_reg,
   output logic                 out_mem_write,
   output logic                 out_alu_src,
   output logic                 out_reg_write,
   output logic [1:0]           out_alu_op,
   output logic                 out_illegal
);

   logic [OPCODE_W-1:0]  opcode;
   ctrl_t                dec_ctrl;
   logic                 dec_illegal;
   logic [WORD-1:0]      dec_sext;
   logic                 reg2loc;
   logic                 is_b;
   logic [REG_IDX_W-1:0] rd_idx1;
   logic [REG_IDX_W-1:0] rd_idx2;
   logic [WORD-1:0]      rd_data1;
   logic [WORD-1:0]      rd_data2;
   logic                 load_use;
   logic                 wb_clash;
   logic                 hazard;
   logic                 accept;
   ctrl_t                ctrl_q;

   assign opcode = in_instr[31:21];

   // Opcode decode, immediate extraction and read-port-2 selection.
   always_comb begin
      dec_ctrl    = '0;
      dec_illegal = 1'b0;
      dec_sext    = '0;
      reg2loc     = 1'b0;
      is_b        = 1'b0;
      if (is_rtype(opcode)) begin
         dec_ctrl.alu_op    = ALU_RTYPE;
         dec_ctrl.reg_write = 1'b1;
      end else if (opcode == OP_LDUR) begin
         dec_ctrl.alu_op     = ALU_LDST;
         dec_ctrl.alu_src    = 1'b1;
         dec_ctrl.mem_read   = 1'b1;
         dec_ctrl.mem_to_reg = 1'b1;
         dec_ctrl.reg_write  = 1'b1;
         dec_sext = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end else if (opcode == OP_STUR) begin
         dec_ctrl.alu_op    = ALU_LDST;
         dec_ctrl.alu_src   = 1'b1;
         dec_ctrl.mem_write = 1'b1;
         reg2loc  = 1'b1;
         dec_sext = {{(WORD-9){in_instr[20]}}, in_instr[20:12]};
      end else if (in_instr[31:24] == OP_CBZ) begin
         dec_ctrl.alu_op = ALU_CBZ;
         dec_ctrl.branch = 1'b1;
         reg2loc  = 1'b1;
         dec_sext = {{(WORD-19){in_instr[23]}}, in_instr[23:5]};
      end else if (in_instr[31:26] == OP_B) begin
         dec_ctrl.uncond_branch = 1'b1;
         is_b     = 1'b1;
         dec_sext = {{(WORD-26){in_instr[25]}}, in_instr[25:0]};
      end else begin
         dec_illegal = 1'b1;
      end
   end

   assign rd_idx1 = in_instr[9:5];
   assign rd_idx2 = reg2loc ? in_instr[4:0] : in_instr[20:16];

   legv8_regfile #(
      .WORD     (WORD),
      .ZERO_REG (ZERO_REG)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx1    (rd_idx1),
      .rd_idx2    (rd_idx2),
      .rd_data1_c (rd_data1),
      .rd_data2_c (rd_data2),
      .wr_en      (wb_en),
      .wr_idx     (wb_reg),
      .wr_data    (wb_data)
   );

   // A load in ID/EX cannot supply its result to the instruction behind it.
   assign load_use = out_valid && ctrl_q.mem_read && (out_rd != ZERO_REG) &&
                     ((out_rd == rd_idx1) || (out_rd == rd_idx2));

`ifdef LEGV8_ID_BYPASS_EN
   assign wb_clash = 1'b0;
`else
   // Without forwarding, wait one cycle so the regfile holds the written value.
   assign wb_clash = wb_en && (wb_reg != ZERO_REG) &&
                     ((wb_reg == rd_idx1) || (wb_reg == rd_idx2));
`endif

   assign hazard   = !is_b && (load_use || wb_clash);
   assign in_ready = !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // ID/EX pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_pc         <= '0;
         out_read_data1 <= '0;
         out_read_data2 <= '0;
         out_sign_ext   <= '0;
         out_opcode     <= '0;
         out_rd         <= '0;
         ctrl_q         <= '0;
         out_illegal    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_pc         <= in_pc;
         out_read_data1 <= rd_data1;
         out_read_data2 <= rd_data2;
         out_sign_ext   <= dec_sext;
         out_opcode     <= opcode;
         out_rd         <= in_instr[4:0];
         ctrl_q         <= dec_ctrl;
         out_illegal    <= dec_illegal;
      end else if (hazard && out_ready) begin
         out_valid   <= 1'b0;
         ctrl_q      <= '0;
         out_illegal <= 1'b0;
      end else if (!out_valid || out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_uncond_branch = ctrl_q.uncond_branch;
   assign out_branch        = ctrl_q.branch;
   assign out_mem_read      = ctrl_q.mem_read;
   assign out_mem_to_reg    = ctrl_q.mem_to_reg;
   assign out_mem_write     = ctrl_q.mem_write;
   assign out_alu_src       = ctrl_q.alu_src;
   assign out_reg_write     = ctrl_q.reg_write;
   assign out_alu_op        = ctrl_q.alu_op;

endmodule

// File: tb/tb_legv8_id_stage.sv
// Directed bench for legv8_id_stage: expected ID/EX contents are queued at issue
// and compared whenever the stage presents a valid instruction.
module tb_legv8_id_stage;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   // {uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0]}
   localparam logic [8:0] CT_R   = 9'b0000001_10;
   localparam logic [8:0] CT_LD  = 9'b0011011_00;
   localparam logic [8:0] CT_ST  = 9'b0000110_00;
   localparam logic [8:0] CT_CBZ = 9'b0100000_01;
   localparam logic [8:0] CT_B   = 9'b1000000_00;
   localparam logic [8:0] CT_NO  = 9'b0000000_00;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc, wb_data;
   logic [4:0]  wb_reg, out_rd;
   logic [63:0] out_pc, out_read_data1, out_read_data2, out_sign_ext;
   logic [10:0] out_opcode;
   logic        out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg;
   logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
   logic [1:0]  out_alu_op;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc, d1, d2, sext;
      logic [8:0]  ctrl;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   legv8_id_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_read_data1(out_read_data1), .out_read_data2(out_read_data2),
      .out_sign_ext(out_sign_ext), .out_opcode(out_opcode), .out_rd(out_rd),
      .out_uncond_branch(out_uncond_branch), .out_branch(out_branch),
      .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
      .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
      .out_reg_write(out_reg_write), .out_alu_op(out_alu_op),
      .out_illegal(out_illegal)
   );

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, rt);
      return {op, imm, 2'b00, rn, rt};
   endfunction

   function automatic logic [8:0] ctrl_vec();
      return {out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg,
              out_mem_write, out_alu_src, out_reg_write, out_alu_op};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] r, input logic [63:0] d);
      wb_en   = 1'b1;
      wb_reg  = r;
      wb_data = d;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [63:0] pc, d1, d2, sext,
                        input logic [8:0] ctrl, input logic ill);
      exp_t e;
      e.instr = instr; e.pc = pc; e.d1 = d1; e.d2 = d2; e.sext = sext;
      e.ctrl = ctrl; e.ill = ill;
      sb.push_back(e);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   // Scoreboard: every live ID/EX value must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb[0];
            check("out_pc",     out_pc,                  mon_e.pc);
            check("read_data1", out_read_data1,          mon_e.d1);
            check("read_data2", out_read_data2,          mon_e.d2);
            check("sign_ext",   out_sign_ext,            mon_e.sext);
            check("opcode",     64'(out_opcode),         64'(mon_e.instr[31:21]));
            check("rd",         64'(out_rd),             64'(mon_e.instr[4:0]));
            check("ctrl",       64'(ctrl_vec()),         64'(mon_e.ctrl));
            check("illegal",    64'(out_illegal),        64'(mon_e.ill));
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid",  64'(out_valid), 64'd0);
      check("rst_pc",     out_pc, 64'd0);
      check("rst_d1",     out_read_data1, 64'd0);
      check("rst_d2",     out_read_data2, 64'd0);
      check("rst_sext",   out_sign_ext, 64'd0);
      check("rst_opcode", 64'(out_opcode), 64'd0);
      check("rst_rd",     64'(out_rd), 64'd0);
      check("rst_ctrl",   64'(ctrl_vec()), 64'd0);
      check("rst_ill",    64'(out_illegal), 64'd0);
      check("rst_ready",  64'(in_ready), 64'd1);
      tick();
      rst_n = 1'b1;

      wb(5'd1, 64'd5);    tick();
      wb(5'd2, 64'd7);    tick();
      wb(5'd4, 64'h44);   tick();
      wb_en = 1'b0;

      // ADD X3, X1, X2
      issue(enc_r(OP_ADD, 5'd2, 5'd1, 5'd3), 64'h100, 64'd5, 64'd7, 64'd0, CT_R, 1'b0);
      @(negedge clk); check("add_ready", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      @(negedge clk);
      check("add_valid",  64'(out_valid), 64'd1);
      check("add_alu_op", 64'(out_alu_op), 64'd2);
      tick();

      // LDUR X4, [X1,#-8] then dependent ADD X5, X4, X2: one bubble
      issue(enc_d(OP_LDUR, 9'h1F8, 5'd1, 5'd4), 64'h104, 64'd5, 64'd0,
            64'hFFFF_FFFF_FFFF_FFF8, CT_LD, 1'b0);
      @(negedge clk); check("ldur_ready", 64'(in_ready), 64'd1);
      tick();
      issue(enc_r(OP_ADD, 5'd2, 5'd4, 5'd5), 64'h108, 64'h44, 64'd7, 64'd0, CT_R, 1'b0);
      @(negedge clk); check("load_use_stall", 64'(in_ready), 64'd0);
      tick();
      @(negedge clk);
      check("bubble_valid",    64'(out_valid), 64'd0);
      check("bubble_mem_read", 64'(out_mem_read), 64'd0);
      check("bubble_ready",    64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      @(negedge clk); check("after_bubble_valid", 64'(out_valid), 64'd1);
      tick();

      // B after a load: no hazard even though imm bits alias the load target
      issue(enc_d(OP_LDUR, 9'h1F8, 5'd1, 5'd4), 64'h10C, 64'd5, 64'd0,
            64'hFFFF_FFFF_FFFF_FFF8, CT_LD, 1'b0);
      tick();
      issue({6'b000101, 26'd128}, 64'h110, 64'h44, 64'd0, 64'd128, CT_B, 1'b0);
      @(negedge clk); check("b_no_hazard", 64'(in_ready), 64'd1);
      tick();
      // Load to X31 never causes a hazard
      issue(enc_d(OP_LDUR, 9'd0, 5'd1, 5'd31), 64'h114, 64'd5, 64'd0, 64'd0, CT_LD, 1'b0);
      tick();
      issue(enc_r(OP_ADD, 5'd2, 5'd31, 5'd9), 64'h118, 64'd0, 64'd7, 64'd0, CT_R, 1'b0);
      @(negedge clk); check("zr_no_hazard", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      tick();

      // Back-pressure: SUB held for 3 cycles while ORR waits
      issue(enc_r(OP_SUB, 5'd1, 5'd2, 5'd6), 64'h120, 64'd7, 64'd5, 64'd0, CT_R, 1'b0);
      tick();
      out_ready = 1'b0;
      issue(enc_r(OP_ORR, 5'd2, 5'd1, 5'd7), 64'h124, 64'd5, 64'd7, 64'd0, CT_R, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk); check("release_ready", 64'(in_ready), 64'd1);
      tick();

      // Flush kills held ORR and blocks AND for one cycle
      out_ready = 1'b0; flush = 1'b1;
      issue(enc_r(OP_AND, 5'd2, 5'd1, 5'd8), 64'h128, 64'd5, 64'd7, 64'd0, CT_R, 1'b0);
      @(negedge clk); check("flush_ready", 64'(in_ready), 64'd0);
      tick();
      void'(sb.pop_front());
      flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("flush_kill",     64'(out_valid), 64'd0);
      check("reaccept_ready", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      @(negedge clk); check("reaccept_valid", 64'(out_valid), 64'd1);
      tick();

      // Illegal opcode flows through with no control
      issue({11'h7FF, 21'd0}, 64'h12C, 64'd0, 64'd0, 64'd0, CT_NO, 1'b1);
      tick(); in_valid = 1'b0;
      @(negedge clk); check("illegal_flag", 64'(out_illegal), 64'd1);
      tick();

      // STUR uses Rt on port 2; CBZ sign-extends imm19
      issue(enc_d(OP_STUR, 9'd16, 5'd1, 5'd2), 64'h130, 64'd5, 64'd7, 64'd16, CT_ST, 1'b0);
      tick();
      issue({8'b10110100, 19'h7FFFD, 5'd2}, 64'h134, 64'd0, 64'd7,
            64'hFFFF_FFFF_FFFF_FFFD, CT_CBZ, 1'b0);
      tick(); in_valid = 1'b0;
      tick();

      // Load-use through STUR's Rt
      issue(enc_d(OP_LDUR, 9'd0, 5'd1, 5'd5), 64'h138, 64'd5, 64'd0, 64'd0, CT_LD, 1'b0);
      tick();
      issue(enc_d(OP_STUR, 9'd0, 5'd1, 5'd5), 64'h13C, 64'd5, 64'd0, 64'd0, CT_ST, 1'b0);
      @(negedge clk); check("stur_rt_hazard", 64'(in_ready), 64'd0);
      tick();
      @(negedge clk); check("stur_rt_ready", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      tick();

      // Writes to X31 are dropped
      wb(5'd31, 64'h99);
      tick(); wb_en = 1'b0;
      issue(enc_r(OP_ADD, 5'd31, 5'd31, 5'd10), 64'h140, 64'd0, 64'd0, 64'd0, CT_R, 1'b0);
      tick(); in_valid = 1'b0;
      tick();

      // Writeback to a register read in the same cycle
      wb(5'd1, 64'h55);
      issue(enc_r(OP_ADD, 5'd2, 5'd1, 5'd11), 64'h144, 64'h55, 64'd7, 64'd0, CT_R, 1'b0);
`ifdef LEGV8_ID_BYPASS_EN
      @(negedge clk); check("wb_bypass_ready", 64'(in_ready), 64'd1);
      tick(); wb_en = 1'b0;
`else
      @(negedge clk); check("wb_clash_stall", 64'(in_ready), 64'd0);
      tick(); wb_en = 1'b0;
      @(negedge clk); check("wb_clash_ready", 64'(in_ready), 64'd1);
      tick();
`endif
      in_valid = 1'b0;
      tick();

      // Asynchronous reset mid-operation drops the held instruction and clears regs
      in_valid = 1'b1; in_instr = enc_r(OP_ADD, 5'd2, 5'd1, 5'd3); in_pc = 64'h148;
      tick(); in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid",  64'(out_valid), 64'd0);
      check("async_rst_pc",     out_pc, 64'd0);
      check("async_rst_regwr",  64'(out_reg_write), 64'd0);
      tick();
      rst_n = 1'b1;
      issue(enc_r(OP_ADD, 5'd2, 5'd1, 5'd3), 64'h14C, 64'd0, 64'd0, 64'd0, CT_R, 1'b0);
      tick(); in_valid = 1'b0;
      repeat (2) tick();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/legv8_id_stage.md
# legv8_id_stage

Pipelined LEGv8 instruction-decode stage with a registered ID/EX output, an internal 32-entry register file and load-use hazard detection. It sits between the fetch stage (valid/ready instruction stream) and the execute stage, and takes writeback from the end of the pipe. It generalises the combinational decode stage: the data width is parametrised, both sides have a handshake, and the stage adds stall, flush and an illegal-opcode flag.

## Interface
- WORD, 64, datapath and register width.
- INSTR_LEN, 32, instruction width; opcode fields are taken from bits [31:21].
- ZERO_REG, 31, register index that always reads 0; writes to it are ignored.

Clocking: one clock; reset is asynchronous and active-low.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  INSTR_LEN  instruction word.
- in_pc  in  WORD  PC of the instruction.
- flush  in  1  kill the instruction held in ID/EX and block acceptance this cycle.
- wb_en  in  1  register-file write enable.
- wb_reg  in  5  write index.
- wb_data  in  WORD  write data.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  execute consumes ID/EX this cycle.
- out_pc, out_read_data1, out_read_data2, out_sign_ext  out  WORD each  registered operands.
- out_opcode  out  11  instr[31:21].
- out_rd  out  5  instr[4:0].
- out_uncond_branch, out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  out  1 each  control signals.
- out_alu_op  out  2  ALU operation class.
- out_illegal  out  1  opcode not recognised.

## Operation
- Decoded opcodes:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000. alu_op = 10, reg_write = 1.
  - LDUR 11111000010: alu_src, mem_read, mem_to_reg, reg_write; alu_op = 00.
  - STUR 11111000000: alu_src, mem_write; alu_op = 00; reg2loc selects instr[4:0].
  - CBZ, instr[31:24] = 10110100: branch; alu_op = 01; reg2loc selects instr[4:0].
  - B, instr[31:26] = 000101: uncond_branch.
- Any other opcode: all control outputs 0 and out_illegal = 1. The instruction still flows through the stage.
- Sign extension to WORD:
  - D-type: instr[20:12].
  - CB: instr[23:5].
  - B: instr[25:0].
  - R-type: 0.
- Read port 1 index is instr[9:5]. Read port 2 index is instr[20:16], or instr[4:0] for STUR and CBZ.
- Any read of ZERO_REG returns 0.
- Register file: the write occurs on the clock edge when wb_en = 1 and wb_reg != ZERO_REG.
- Load-use hazard condition, all of:
  - out_valid = 1 and out_mem_read = 1 and out_rd != ZERO_REG;
  - out_rd equals the read-1 index, or the active read-2 index.
  - B instructions never hazard.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- ID/EX update priority, highest first:
  - flush → out_valid <= 0.
  - Accept (in_valid && in_ready) → load the decoded fields and out_valid <= 1.
  - Hazard && out_ready → load a bubble: out_valid <= 0, all control outputs 0.
  - !out_valid || out_ready (no new instruction) → out_valid <= 0.
  - Otherwise → hold all outputs.
- Reset values:
  - Every output register is 0.
  - All 32 register-file entries are 0.
  - in_ready follows its combinational equation.

## Timing
- Latency: an instruction accepted on edge N appears on the outputs from edge N with out_valid = 1.
- A load followed by a dependent instruction costs exactly one bubble cycle.
- Simultaneous wb_en and a read of the same register in the accept cycle: see Configuration.
- Simultaneous flush and in_valid: the instruction is not accepted; fetch must re-present it.
- Reset asserted mid-operation: outputs clear immediately (asynchronously); the instruction held in ID/EX is lost.

## Configuration
- LEGV8_ID_BYPASS_EN defined: a write (wb_en, wb_reg != ZERO_REG) whose index matches a read index in the same cycle forwards wb_data into the operand latched into ID/EX.
- LEGV8_ID_BYPASS_EN undefined: the hazard condition also fires on that match. The stage stalls one cycle, then reads the updated value from the register file.

## Structure
- Shared package legv8_pkg:
  - opcode constants;
  - alu_op encodings (ALU_LDST = 00, ALU_CBZ = 01, ALU_RTYPE = 10);
  - the ZERO_REG default;
  - a packed struct for the control bundle.
- Sub-module legv8_regfile:
  - 32 × WORD storage with asynchronous reset;
  - two combinational read ports;
  - one synchronous write port;
  - zero-register handling;
  - optional bypass.

## Test plan
- Reset, then write X1 = 5 and X2 = 7 via wb, then ADD X3, X1, X2 → next cycle out_read_data1 = 5, out_read_data2 = 7, out_alu_op = 10, out_reg_write = 1.
- LDUR X4, [X1, #-8] → out_sign_ext = 0xFFFF_FFFF_FFFF_FFF8, out_mem_read = 1, out_alu_src = 1.
- LDUR X4, then ADD X5, X4, X2 back-to-back with out_ready = 1 → in_ready = 0 for one cycle, one bubble (out_valid = 0), then the ADD issues.
- out_ready held 0 for 3 cycles while out_valid = 1 → all outputs stable and in_ready = 0; no instruction is lost.
- Flush asserted with in_valid high → next cycle out_valid = 0, and the instruction is re-accepted one cycle later.
- Opcode 0x7FF → out_illegal = 1, all control outputs 0. A write to X31 followed by a read of X31 returns 0.
